rca_resp_checker: RTL and testbench

Synthesizable response checker for the `rca` ripple-carry adder, on the observing side of the adder's stimulus stream. It samples each operand pair together with the adder's sum and carry, computes the golden result, and counts vectors and mismatches over a run of NUM_VEC vectors. It reports pass/fail for on-board self-test alongside the stimulus source driving `rca`.

---
 rtl/rca_resp_checker.sv | 173 +++++++++++++++++
 tb/tb_rca_resp_checker.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_resp_checker.sv
// Response checker for the rca ripple-carry adder: registers each valid vector,
// compares {c,s} against a+b one edge later, counts vectors/mismatches per run.
// Optional first-fail capture when RCA_CHK_FIRSTFAIL_EN is defined.
module rca_resp_checker #(
    parameter int WIDTH   = 4,
    parameter int NUM_VEC = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             vld,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] s,
    input  logic             c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       vec_cnt,
    output logic [7:0]       err_cnt
`ifdef RCA_CHK_FIRSTFAIL_EN
    ,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_s,
    output logic             fail_c
`endif
);

    // state | meaning
    // IDLE  | waiting for the first start after reset
    // RUN   | accepting and comparing vectors
    // DONE  | NUM_VEC vectors compared; results held until start
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0] NUM_VEC_L = 8'(NUM_VEC);

    state_t           state_q, state_d;
    logic [7:0]       acc_cnt_q, acc_cnt_d;
    logic [7:0]       vec_cnt_q, vec_cnt_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             s1_vld_q, s1_vld_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_s_q, s1_s_d;
    logic             s1_c_q, s1_c_d;
    logic [WIDTH:0]   expected;
    logic             mismatch;

`ifdef RCA_CHK_FIRSTFAIL_EN
    logic [WIDTH-1:0] fail_a_q, fail_a_d, fail_b_q, fail_b_d, fail_s_q, fail_s_d;
    logic             fail_c_q, fail_c_d;
    logic             fail_seen_q, fail_seen_d;
`endif

    assign expected = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    assign mismatch = s1_vld_q && (expected != {s1_c_q, s1_s_q});

    always_comb begin
        state_d   = state_q;
        acc_cnt_d = acc_cnt_q;
        vec_cnt_d = vec_cnt_q;
        err_cnt_d = err_cnt_q;
        s1_vld_d  = 1'b0;
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        s1_s_d    = s1_s_q;
        s1_c_d    = s1_c_q;
`ifdef RCA_CHK_FIRSTFAIL_EN
        fail_a_d    = fail_a_q;
        fail_b_d    = fail_b_q;
        fail_s_d    = fail_s_q;
        fail_c_d    = fail_c_q;
        fail_seen_d = fail_seen_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    acc_cnt_d = 8'd0;
                    vec_cnt_d = 8'd0;
                    err_cnt_d = 8'd0;
`ifdef RCA_CHK_FIRSTFAIL_EN
                    fail_a_d    = '0;
                    fail_b_d    = '0;
                    fail_s_d    = '0;
                    fail_c_d    = 1'b0;
                    fail_seen_d = 1'b0;
`endif
                end
            end
            RUN: begin
                if (vld && (acc_cnt_q < NUM_VEC_L)) begin
                    s1_vld_d  = 1'b1;
                    s1_a_d    = a;
                    s1_b_d    = b;
                    s1_s_d    = s;
                    s1_c_d    = c;
                    acc_cnt_d = acc_cnt_q + 8'd1;
                end
                if (s1_vld_q) begin
                    vec_cnt_d = vec_cnt_q + 8'd1;
                    if (mismatch && (err_cnt_q != 8'hff))
                        err_cnt_d = err_cnt_q + 8'd1;
                    if (vec_cnt_d == NUM_VEC_L)
                        state_d = DONE;
`ifdef RCA_CHK_FIRSTFAIL_EN
                    if (mismatch && !fail_seen_q) begin
                        fail_a_d    = s1_a_q;
                        fail_b_d    = s1_b_q;
                        fail_s_d    = s1_s_q;
                        fail_c_d    = s1_c_q;
                        fail_seen_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_cnt_q <= 8'd0;
            vec_cnt_q <= 8'd0;
            err_cnt_q <= 8'd0;
            s1_vld_q  <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_s_q    <= '0;
            s1_c_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_cnt_q <= acc_cnt_d;
            vec_cnt_q <= vec_cnt_d;
            err_cnt_q <= err_cnt_d;
            s1_vld_q  <= s1_vld_d;
            s1_a_q    <= s1_a_d;
            s1_b_q    <= s1_b_d;
            s1_s_q    <= s1_s_d;
            s1_c_q    <= s1_c_d;
        end
    end

`ifdef RCA_CHK_FIRSTFAIL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fail_a_q    <= '0;
            fail_b_q    <= '0;
            fail_s_q    <= '0;
            fail_c_q    <= 1'b0;
            fail_seen_q <= 1'b0;
        end else begin
            fail_a_q    <= fail_a_d;
            fail_b_q    <= fail_b_d;
            fail_s_q    <= fail_s_d;
            fail_c_q    <= fail_c_d;
            fail_seen_q <= fail_seen_d;
        end
    end

    assign fail_a = fail_a_q;
    assign fail_b = fail_b_q;
    assign fail_s = fail_s_q;
    assign fail_c = fail_c_q;
`endif

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign pass    = done && (err_cnt_q == 8'd0);
    assign vec_cnt = vec_cnt_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_rca_resp_checker.sv
// Scoreboard bench for rca_resp_checker: stimulus pushes expected counter
// snapshots, a negedge monitor pops one on each vec_cnt increment.
module tb_rca_resp_checker;

    logic       clk = 1'b0;
    logic       reset, start, start1, vld, c;
    logic [3:0] a, b, s, s_sat;
    logic       busy, done, pass, busy1, done1, pass1;
    logic [7:0] vec_cnt, err_cnt, vec_cnt1, err_cnt1;
`ifdef RCA_CHK_FIRSTFAIL_EN
    logic [3:0] fail_a, fail_b, fail_s, fail_a1, fail_b1, fail_s1;
    logic       fail_c, fail_c1;
`endif

    always #5 clk = ~clk;

    rca_resp_checker #(.WIDTH(4), .NUM_VEC(6)) dut (
        .clk(clk), .reset(reset), .start(start), .vld(vld),
        .a(a), .b(b), .s(s), .c(c),
        .busy(busy), .done(done), .pass(pass), .vec_cnt(vec_cnt), .err_cnt(err_cnt)
`ifdef RCA_CHK_FIRSTFAIL_EN
        , .fail_a(fail_a), .fail_b(fail_b), .fail_s(fail_s), .fail_c(fail_c)
`endif
    );

    rca_resp_checker #(.WIDTH(4), .NUM_VEC(255)) dut_sat (
        .clk(clk), .reset(reset), .start(start1), .vld(vld),
        .a(a), .b(b), .s(s_sat), .c(c),
        .busy(busy1), .done(done1), .pass(pass1), .vec_cnt(vec_cnt1), .err_cnt(err_cnt1)
`ifdef RCA_CHK_FIRSTFAIL_EN
        , .fail_a(fail_a1), .fail_b(fail_b1), .fail_s(fail_s1), .fail_c(fail_c1)
`endif
    );

    typedef struct {
        int vc;
        int ec;
        bit dn;
        bit ps;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   m_vec, m_err;
    logic [7:0] prev_vec = 8'd0;

    int va[6] = '{0, 1, 1, 3, 15, 10};
    int vb[6] = '{0, 1, 2, 2, 1, 11};
    int vs[6] = '{0, 2, 3, 5, 0, 5};
    int vc[6] = '{0, 0, 0, 0, 1, 1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (vec_cnt != prev_vec && vec_cnt != 8'd0) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_update: got vec_cnt %0d expected no update", vec_cnt);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("mon_vec_cnt", int'(vec_cnt), e.vc);
                chk("mon_err_cnt", int'(err_cnt), e.ec);
                chk("mon_done", int'(done), int'(e.dn));
                chk("mon_pass", int'(pass), int'(e.ps));
                chk("mon_cycle", cyc, e.cyc);
            end
        end
        prev_vec = vec_cnt;
    end

    // acc: this vector is expected to be accepted and compared by dut
    task automatic drive(input bit st, input bit v, input int av, input int bv,
                         input int sv, input int cv, input bit acc);
        exp_t e;
        start = st;
        vld   = v;
        a     = 4'(av);
        b     = 4'(bv);
        s     = 4'(sv);
        c     = cv[0];
        if (acc) begin
            m_vec++;
            if ((av + bv) != (cv * 16 + sv) && m_err < 255) m_err++;
            e.vc  = m_vec;
            e.ec  = m_err;
            e.dn  = (m_vec == 6);
            e.ps  = (m_vec == 6) && (m_err == 0);
            e.cyc = cyc + 2;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        vld   = 1'b0;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start1 = 1'b0; vld = 1'b0;
        a = '0; b = '0; s = '0; s_sat = '0; c = 1'b0;
        m_vec = 0; m_err = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_vec_cnt", int'(vec_cnt), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
`ifdef RCA_CHK_FIRSTFAIL_EN
        chk("rst_fail_a", int'(fail_a), 0);
        chk("rst_fail_c", int'(fail_c), 0);
`endif
        reset = 1'b0;

        // vld before any start
        drive(0, 1, 1, 1, 2, 0, 0);
        drive(0, 1, 1, 1, 2, 0, 0);
        idle();
        chk("pre_start_vec_cnt", int'(vec_cnt), 0);
        chk("pre_start_busy", int'(busy), 0);

        // correct adder, continuous vld
        m_vec = 0; m_err = 0;
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("good_busy_after_start", int'(busy), 1);
        for (int i = 0; i < 6; i++) drive(0, 1, va[i], vb[i], vs[i], vc[i], 1);
        idle();
        chk("good_done", int'(done), 1);
        chk("good_pass", int'(pass), 1);
        chk("good_vec_cnt", int'(vec_cnt), 6);
        chk("good_err_cnt", int'(err_cnt), 0);
        chk("good_busy_end", int'(busy), 0);

        // vld in DONE is ignored
        drive(0, 1, 2, 2, 4, 0, 0);
        drive(0, 1, 2, 2, 4, 0, 0);
        idle();
        chk("done_vld_vec_cnt", int'(vec_cnt), 6);
        chk("done_vld_done", int'(done), 1);

        // fault run: carry stuck at 0; start with simultaneous vld from DONE
        m_vec = 0; m_err = 0;
        drive(1, 1, 3, 3, 6, 0, 0);
        chk("fault_busy_after_start", int'(busy), 1);
        chk("fault_vec_cleared", int'(vec_cnt), 0);
        chk("fault_err_cleared", int'(err_cnt), 0);
        for (int i = 0; i < 6; i++) drive(0, 1, va[i], vb[i], vs[i], 0, 1);
        idle();
        chk("fault_err_cnt", int'(err_cnt), 2);
        chk("fault_pass", int'(pass), 0);
        chk("fault_done", int'(done), 1);
`ifdef RCA_CHK_FIRSTFAIL_EN
        chk("fault_fail_a", int'(fail_a), 15);
        chk("fault_fail_b", int'(fail_b), 1);
        chk("fault_fail_s", int'(fail_s), 0);
        chk("fault_fail_c", int'(fail_c), 0);
`endif

        // gapped vld with a start pulse mid-run and extra vld after acceptance
        m_vec = 0; m_err = 0;
        drive(1, 0, 0, 0, 0, 0, 0);
        begin
            int k;
            k = 0;
            for (int t = 1; t <= 14; t++) begin
                if (t == 1 || t == 3 || t == 4 || t == 8 || t == 9 || t == 12) begin
                    drive(0, 1, va[k], vb[k], vs[k], vc[k], 1);
                    k++;
                end else if (t == 6) begin
                    drive(1, 0, 0, 0, 0, 0, 0);
                    chk("mid_start_no_clear", int'(vec_cnt), 3);
                    chk("mid_start_busy", int'(busy), 1);
                end else if (t == 13 || t == 14) begin
                    drive(0, 1, 1, 1, 2, 0, 0);
                end else begin
                    idle();
                end
            end
        end
        idle();
        chk("gap_vec_cnt", int'(vec_cnt), 6);
        chk("gap_done", int'(done), 1);
        chk("gap_pass", int'(pass), 1);
`ifdef RCA_CHK_FIRSTFAIL_EN
        chk("gap_fail_a_cleared", int'(fail_a), 0);
`endif

        // reset mid-run with the 4th vector sitting in stage 1
        m_vec = 0; m_err = 0;
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, va[i], vb[i], vs[i], 0, 1);
        drive(0, 1, 3, 2, 0, 0, 0);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        chk("midrst_vec_cnt", int'(vec_cnt), 0);
        chk("midrst_err_cnt", int'(err_cnt), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_pass", int'(pass), 0);
        idle();
        chk("midrst_no_late_count", int'(vec_cnt), 0);
        m_vec = 0; m_err = 0;
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 15, 1, 0, 1, 1);
        drive(0, 1, 10, 11, 5, 1, 1);
        idle();
        chk("fresh_vec_cnt", int'(vec_cnt), 2);
        chk("fresh_busy", int'(busy), 1);
        reset = 1'b1;
        idle();
        reset = 1'b0;

        // saturation instance: every sum wrong over 255 vectors
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        for (int i = 0; i < 255; i++) begin
            vld = 1'b1; a = 4'd3; b = 4'd4; c = 1'b0; s_sat = 4'd6;
            @(posedge clk);
            #1;
        end
        vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sat_vec_cnt", int'(vec_cnt1), 255);
        chk("sat_err_cnt", int'(err_cnt1), 255);
        chk("sat_done", int'(done1), 1);
        chk("sat_pass", int'(pass1), 0);
        chk("sat_main_idle_vec", int'(vec_cnt), 0);

        chk("scoreboard_drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
